// File: rtl/pc_fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_stage_pkg
// Shared definitions for the program-counter / instruction-fetch stage:
//   XLEN          - PC and instruction width
//   RESET_PC      - PC loaded by reset
//   PC_STEP       - sequential PC increment
//   NOP           - canonical no-op instruction word, handy for benches
//   fetch_state_t - fetch FSM state encoding
// ---------------------------------------------------------------------------
package pc_fetch_stage_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          PC_STEP  = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    // IDLE: post-reset settle cycle
    // REQ : presenting a request to instruction memory
    // WAIT: one request accepted, response pending
    // DROP: one request accepted, but its response belongs to a squashed fetch
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_stage_if
// Bundles every non-clock signal of the fetch stage.
//   redirect, pc_next         - next-PC mux select / output (into fetch)
//   pc_plus_step              - sequential PC, feeds mux input a (out of fetch)
//   imem_req_valid/addr/ready - instruction memory request channel
//   imem_rsp_valid/data       - instruction memory response strobe (no backpressure)
//   if_valid/if_pc/if_instr   - registered decode slot
//   id_ready                  - decode consumes the slot
// master: the fetch stage.  slave: memory, decode and next-PC mux side.
// ---------------------------------------------------------------------------
interface pc_fetch_stage_if #(
    parameter int XLEN = pc_fetch_stage_pkg::XLEN
);

    logic            redirect;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_plus_step;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;

    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;
    logic            id_ready;

    modport master (
        input  redirect,
        input  pc_next,
        output pc_plus_step,
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output if_valid,
        output if_pc,
        output if_instr,
        input  id_ready
    );

    modport slave (
        output redirect,
        output pc_next,
        input  pc_plus_step,
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  if_valid,
        input  if_pc,
        input  if_instr,
        output id_ready
    );

endinterface

// File: rtl/pc_fetch_stage_pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// XLEN-wide program-counter register with synchronous active-high reset to
// RESET_PC and a load enable.
//   clk  - clock
//   rst  - synchronous reset, loads RESET_PC
//   load - capture d on this edge
//   d    - next PC value
//   q    - current PC
// ---------------------------------------------------------------------------
module pc_reg #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_fetch_stage.sv
// ---------------------------------------------------------------------------
// pc_fetch_stage
// Holds the architectural fetch PC, issues single-outstanding requests to
// instruction memory and presents fetched instructions to decode through a
// registered valid/ready slot. The next-PC select mux lives in the parent:
// this block drives its input a (pc_plus_step) and consumes its output y
// (pc_next) whenever redirect (the mux select) is high.
//   clk - single clock, rising edge
//   rst - synchronous active-high reset
//   bus - pc_fetch_stage_if master modport (see interface for signal list)
// ---------------------------------------------------------------------------
module pc_fetch_stage #(
    parameter int              XLEN     = pc_fetch_stage_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = pc_fetch_stage_pkg::RESET_PC,
    parameter int              PC_STEP  = pc_fetch_stage_pkg::PC_STEP
) (
    input  logic             clk,
    input  logic             rst,
    pc_fetch_stage_if.master bus
);

    import pc_fetch_stage_pkg::*;

    fetch_state_t    state;
    fetch_state_t    state_next;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus;
    logic [XLEN-1:0] fetch_pc;
    logic            pc_load;
    logic            handshake;
    logic            redirect_act;
    logic            slot_load;

    // Redirect is ignored in IDLE; everywhere else it wins over all other events.
    assign redirect_act = bus.redirect && (state != IDLE);

    // Only request when the slot will be free by the time the response lands:
    // either it is empty now or decode is draining it this cycle.
    assign bus.imem_req_valid = (state == REQ) && (!bus.if_valid || bus.id_ready);
    assign handshake          = bus.imem_req_valid && bus.imem_req_ready;

    // Unsigned XLEN-bit add, wraps silently at the top of the address space.
    assign pc_plus           = pc + XLEN'(PC_STEP);
    assign bus.pc_plus_step  = pc_plus;
    assign bus.imem_req_addr = pc;

    // Redirect has priority over the sequential advance of an accepted request.
    assign pc_load = redirect_act || handshake;
    assign pc_d    = redirect_act ? bus.pc_next : pc_plus;

    // A response is kept only if it belongs to the live fetch and no redirect
    // squashes it in the same cycle.
    assign slot_load = (state == WAIT) && bus.imem_rsp_valid && !redirect_act;

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .load (pc_load),
        .d    (pc_d),
        .q    (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A response seen in IDLE or REQ can only be a leftover from before reset,
    // so those states never look at imem_rsp_valid.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                if (handshake) begin
                    state_next = redirect_act ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    state_next = REQ;
                end else if (redirect_act) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (bus.imem_rsp_valid) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // PC of the in-flight request, attached to its instruction on return.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= '0;
        end else if (handshake) begin
            fetch_pc <= pc;
        end
    end

    // Decode slot: a load takes precedence over a same-cycle consume, and a
    // redirect empties the slot regardless of either.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.if_valid <= 1'b0;
            bus.if_pc    <= '0;
            bus.if_instr <= '0;
        end else if (redirect_act) begin
            bus.if_valid <= 1'b0;
        end else if (slot_load) begin
            bus.if_valid <= 1'b1;
            bus.if_pc    <= fetch_pc;
            bus.if_instr <= bus.imem_rsp_data;
        end else if (bus.if_valid && bus.id_ready) begin
            bus.if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_stage
// Directed bench for pc_fetch_stage. Inputs are driven 1 time unit after the
// rising edge and outputs are sampled one unit later, well away from the edge.
// The memory is played cycle by cycle by each scenario task; the instruction
// word for an address is addr ^ 32'hA5A5_0000 so slot contents are traceable.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_fetch_stage;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pc_fetch_stage_if bus ();

    pc_fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] instr_for(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.redirect = 1'b0;
        bus.pc_next = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 32'h0;
        bus.id_ready = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid); end
        checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_if_valid: got %b expected 0", bus.if_valid); end
        checks++; if (bus.if_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_if_pc: got %h expected 0", bus.if_pc); end
        checks++; if (bus.if_instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_if_instr: got %h expected 0", bus.if_instr); end
        checks++; if (bus.imem_req_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_req_addr: got %h expected 0", bus.imem_req_addr); end
        checks++; if (bus.pc_plus_step !== 32'h4) begin failures++; $display("[TB] FAIL reset_pc_plus_step: got %h expected 4", bus.pc_plus_step); end
        // First cycle out of reset is IDLE; a stray response here is ignored.
        rst = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_req_valid: got %b expected 0", bus.imem_req_valid); end
        tick();
        bus.imem_rsp_valid = 1'b0;
    endtask

    task automatic test_streaming();
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            a = 32'(k * 4);
            #1;
            checks++; if (bus.imem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL stream_req_valid[%0d]: got %b expected 1", k, bus.imem_req_valid); end
            checks++; if (bus.imem_req_addr !== a) begin failures++; $display("[TB] FAIL stream_req_addr[%0d]: got %h expected %h", k, bus.imem_req_addr, a); end
            checks++; if (bus.if_valid !== (k > 0)) begin failures++; $display("[TB] FAIL stream_slot_valid[%0d]: got %b expected %b", k, bus.if_valid, (k > 0)); end
            if (k > 0) begin
                checks++; if (bus.if_pc !== a - 32'd4) begin failures++; $display("[TB] FAIL stream_if_pc[%0d]: got %h expected %h", k, bus.if_pc, a - 32'd4); end
            end
            tick();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data = instr_for(a);
            #1;
            checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_wait_if_valid[%0d]: got %b expected 0", k, bus.if_valid); end
            tick();
            bus.imem_rsp_valid = 1'b0;
        end
    endtask

    task automatic test_decode_stall();
        // Slot holds 0x4 here; pc is 0x8.
        bus.id_ready = 1'b0;
        #1;
        checks++; if (bus.if_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_if_valid: got %b expected 1", bus.if_valid); end
        checks++; if (bus.if_instr !== instr_for(32'h4)) begin failures++; $display("[TB] FAIL stall_if_instr: got %h expected %h", bus.if_instr, instr_for(32'h4)); end
        checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_req_valid_0: got %b expected 0", bus.imem_req_valid); end
        tick();
        #1;
        checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_req_valid_1: got %b expected 0", bus.imem_req_valid); end
        checks++; if (bus.if_pc !== 32'h4) begin failures++; $display("[TB] FAIL stall_if_pc: got %h expected 4", bus.if_pc); end
        checks++; if (bus.imem_req_addr !== 32'h8) begin failures++; $display("[TB] FAIL stall_req_addr: got %h expected 8", bus.imem_req_addr); end
        tick();
        bus.id_ready = 1'b1;
        #1;
        checks++; if (bus.imem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL release_req_valid: got %b expected 1", bus.imem_req_valid); end
        checks++; if (bus.imem_req_addr !== 32'h8) begin failures++; $display("[TB] FAIL release_req_addr: got %h expected 8", bus.imem_req_addr); end
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = instr_for(32'h8);
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        checks++; if (bus.if_valid !== 1'b1) begin failures++; $display("[TB] FAIL release_if_valid: got %b expected 1", bus.if_valid); end
        checks++; if (bus.if_pc !== 32'h8) begin failures++; $display("[TB] FAIL release_if_pc: got %h expected 8", bus.if_pc); end
    endtask

    task automatic test_redirect_wait();
        // REQ with pc 0xC; accept it, then redirect while its response is pending.
        tick();
        bus.redirect = 1'b1;
        bus.pc_next = 32'h100;
        tick();
        bus.redirect = 1'b0;
        #1;
        checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL drop_req_valid: got %b expected 0", bus.imem_req_valid); end
        checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("[TB] FAIL drop_if_valid: got %b expected 0", bus.if_valid); end
        checks++; if (bus.imem_req_addr !== 32'h100) begin failures++; $display("[TB] FAIL drop_req_addr: got %h expected 100", bus.imem_req_addr); end
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = instr_for(32'hC);
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("[TB] FAIL stale_if_valid: got %b expected 0", bus.if_valid); end
        checks++; if (bus.imem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL redir_req_valid: got %b expected 1", bus.imem_req_valid); end
        checks++; if (bus.imem_req_addr !== 32'h100) begin failures++; $display("[TB] FAIL redir_req_addr: got %h expected 100", bus.imem_req_addr); end
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = instr_for(32'h100);
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        checks++; if (bus.if_pc !== 32'h100) begin failures++; $display("[TB] FAIL redir_if_pc: got %h expected 100", bus.if_pc); end
        checks++; if (bus.if_instr !== instr_for(32'h100)) begin failures++; $display("[TB] FAIL redir_if_instr: got %h expected %h", bus.if_instr, instr_for(32'h100)); end
    endtask

    task automatic test_redirect_with_response();
        // Accept 0x104, then redirect in the very cycle its response arrives.
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = instr_for(32'h104);
        bus.redirect = 1'b1;
        bus.pc_next = 32'h200;
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.redirect = 1'b0;
        #1;
        checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("[TB] FAIL simul_if_valid: got %b expected 0", bus.if_valid); end
        checks++; if (bus.imem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL simul_req_valid: got %b expected 1", bus.imem_req_valid); end
        checks++; if (bus.imem_req_addr !== 32'h200) begin failures++; $display("[TB] FAIL simul_req_addr: got %h expected 200", bus.imem_req_addr); end
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = instr_for(32'h200);
        tick();
        bus.imem_rsp_valid = 1'b0;
    endtask

    task automatic test_wrap_around();
        // Redirect in REQ while memory is not ready: no handshake, stay in REQ.
        bus.imem_req_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.pc_next = 32'hFFFF_FFFC;
        tick();
        bus.redirect = 1'b0;
        bus.imem_req_ready = 1'b1;
        #1;
        checks++; if (bus.imem_req_addr !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_req_addr: got %h expected fffffffc", bus.imem_req_addr); end
        checks++; if (bus.pc_plus_step !== 32'h0) begin failures++; $display("[TB] FAIL wrap_pc_plus_step: got %h expected 0", bus.pc_plus_step); end
        checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("[TB] FAIL wrap_if_valid: got %b expected 0", bus.if_valid); end
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = instr_for(32'hFFFF_FFFC);
        #1;
        checks++; if (bus.imem_req_addr !== 32'h0) begin failures++; $display("[TB] FAIL wrap_next_addr: got %h expected 0", bus.imem_req_addr); end
        tick();
        bus.imem_rsp_valid = 1'b0;
        // Hold the request unaccepted for a cycle: address must not move.
        bus.imem_req_ready = 1'b0;
        #1;
        checks++; if (bus.if_pc !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_if_pc: got %h expected fffffffc", bus.if_pc); end
        tick();
        #1;
        checks++; if (bus.imem_req_addr !== 32'h0) begin failures++; $display("[TB] FAIL hold_req_addr: got %h expected 0", bus.imem_req_addr); end
        checks++; if (bus.imem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL hold_req_valid: got %b expected 1", bus.imem_req_valid); end
        bus.imem_req_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_fetch();
        // In WAIT for address 0 with pc at 0x4.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = instr_for(32'h0);
        bus.imem_req_ready = 1'b0;
        #1;
        checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_idle_req: got %b expected 0", bus.imem_req_valid); end
        tick();
        #1;
        checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_if_valid_0: got %b expected 0", bus.if_valid); end
        checks++; if (bus.imem_req_addr !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_req_addr: got %h expected 0", bus.imem_req_addr); end
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_if_valid_1: got %b expected 0", bus.if_valid); end
        checks++; if (bus.imem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_req_valid: got %b expected 1", bus.imem_req_valid); end
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = instr_for(32'h0);
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        checks++; if (bus.if_valid !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_reload_valid: got %b expected 1", bus.if_valid); end
        checks++; if (bus.if_pc !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_reload_pc: got %h expected 0", bus.if_pc); end
    endtask

    task automatic test_redirect_on_accept();
        // Redirect in the same cycle a request is accepted: its response is stale.
        bus.redirect = 1'b1;
        bus.pc_next = 32'h300;
        tick();
        bus.redirect = 1'b0;
        #1;
        checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL accept_drop_req: got %b expected 0", bus.imem_req_valid); end
        checks++; if (bus.imem_req_addr !== 32'h300) begin failures++; $display("[TB] FAIL accept_drop_addr: got %h expected 300", bus.imem_req_addr); end
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = instr_for(32'h4);
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("[TB] FAIL accept_if_valid: got %b expected 0", bus.if_valid); end
        checks++; if (bus.imem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL accept_req_valid: got %b expected 1", bus.imem_req_valid); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_streaming();
        test_decode_stall();
        test_redirect_wait();
        test_redirect_with_response();
        test_wrap_around();
        test_reset_mid_fetch();
        test_redirect_on_accept();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
